// File: rtl/pulse_sync_arbiter_pkg.sv
// psa_pkg: shared types and constants for pulse_sync_arbiter.
//   psa_state_e  : launch FSM states (IDLE, WAIT_HI, WAIT_LO)
//   PSA_MAX_REQ  : largest supported requester count
//   PSA_DROP_CNT_W : width of the optional merged-request counter
//   psa_popcount : number of set bits in a request-sized vector
package psa_pkg;

  localparam int PSA_MAX_REQ    = 16;
  localparam int PSA_DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } psa_state_e;

  function automatic logic [4:0] psa_popcount(input logic [PSA_MAX_REQ-1:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < PSA_MAX_REQ; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pulse_sync_arbiter_if.sv
// pulse_sync_arbiter_if: request/ack and synchronizer handshake bundle.
//   req        : single-cycle request pulses, one bit per requester
//   ack        : single-cycle launch pulse per requester
//   pending    : registered, not-yet-launched requests
//   sync_sig_a : source pulse into the shared handshake synchronizer
//   sync_busy  : synchronizer busy flag (clk_a domain)
//   sync_id    : requester ID qualifying the in-flight pulse
//   drop_cnt   : merged-request counter, only with PSA_DROP_CNT_EN defined
// Modports: master = requester/synchronizer side, slave = arbiter side.
interface pulse_sync_arbiter_if
  import psa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] pending;
  logic               sync_sig_a;
  logic               sync_busy;
  logic [ID_W-1:0]    sync_id;
`ifdef PSA_DROP_CNT_EN
  logic [PSA_DROP_CNT_W-1:0] drop_cnt;

  modport master (output req, output sync_busy,
                  input ack, input pending, input sync_sig_a, input sync_id, input drop_cnt);
  modport slave  (input req, input sync_busy,
                  output ack, output pending, output sync_sig_a, output sync_id, output drop_cnt);
`else
  modport master (output req, output sync_busy,
                  input ack, input pending, input sync_sig_a, input sync_id);
  modport slave  (input req, input sync_busy,
                  output ack, output pending, output sync_sig_a, output sync_id);
`endif

endinterface

// File: rtl/pulse_sync_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner selection.
//   pending      : candidate requests
//   pointer      : highest-priority index for this pick
//   grant_onehot : one-hot winner
//   grant_id     : winner index
//   grant_valid  : a winner exists
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  // Search from pointer up to the top, then wrap and search below pointer.
  always_comb begin
    grant_onehot = {NUM_REQ{1'b0}};
    grant_id     = {ID_W{1'b0}};
    grant_valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && pending[i] && (i >= int'(pointer))) begin
        grant_valid     = 1'b1;
        grant_id        = ID_W'(i);
        grant_onehot[i] = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && pending[i] && (i < int'(pointer))) begin
        grant_valid     = 1'b1;
        grant_id        = ID_W'(i);
        grant_onehot[i] = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/pulse_sync_arbiter.sv
// pulse_sync_arbiter: collects request pulses from NUM_REQ requesters and
// launches them one at a time through a shared handshake pulse
// synchronizer, round-robin, tagging each launch with sync_id.
//   clk_a   : clock
//   rst_a_n : asynchronous active-low reset
//   bus     : pulse_sync_arbiter_if.slave (req/ack/pending/sync_*)
// Optional feature macro: PSA_DROP_CNT_EN adds bus.drop_cnt, a saturating
// count of requests merged into an already-pending request.
module pulse_sync_arbiter
  import psa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_a,
  input  logic                 rst_a_n,
  pulse_sync_arbiter_if.slave  bus
);

  psa_state_e         state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [NUM_REQ-1:0] pending_r;
  logic [NUM_REQ-1:0] ack_r;
  logic               sync_sig_r;
  logic [ID_W-1:0]    sync_id_r;

  logic [NUM_REQ-1:0] grant_onehot_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               grant_valid_s;
  logic               launch_s;
  logic [NUM_REQ-1:0] clear_s;
  logic [NUM_REQ-1:0] pending_nxt_s;
  logic [ID_W-1:0]    ptr_nxt_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .pending      (pending_r),
    .pointer      (ptr_r),
    .grant_onehot (grant_onehot_s),
    .grant_id     (grant_id_s),
    .grant_valid  (grant_valid_s)
  );

  // Launch decision, pending update (set wins over clear) and next pointer.
  always_comb begin
    launch_s = (state_r == IDLE) && grant_valid_s && !bus.sync_busy;
    if (launch_s) begin
      clear_s = grant_onehot_s;
    end else begin
      clear_s = {NUM_REQ{1'b0}};
    end
    pending_nxt_s = (pending_r & ~clear_s) | bus.req;
    if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = {ID_W{1'b0}};
    end else begin
      ptr_nxt_s = grant_id_s + ID_W'(1);
    end
  end

  // Pending request register.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      pending_r <= {NUM_REQ{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Launch FSM: pulses sync_sig_a/ack on launch, then follows sync_busy
  // high and back low before returning to IDLE, so IDLE must see a free
  // synchronizer for a full cycle before the next launch.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_r    <= IDLE;
      ptr_r      <= {ID_W{1'b0}};
      ack_r      <= {NUM_REQ{1'b0}};
      sync_sig_r <= 1'b0;
      sync_id_r  <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r    <= WAIT_HI;
            sync_sig_r <= 1'b1;
            ack_r      <= grant_onehot_s;
            sync_id_r  <= grant_id_s;
            ptr_r      <= ptr_nxt_s;
          end else begin
            sync_sig_r <= 1'b0;
            ack_r      <= {NUM_REQ{1'b0}};
          end
        end
        WAIT_HI: begin
          sync_sig_r <= 1'b0;
          ack_r      <= {NUM_REQ{1'b0}};
          if (bus.sync_busy) begin
            state_r <= WAIT_LO;
          end else begin
            state_r <= WAIT_HI;
          end
        end
        WAIT_LO: begin
          sync_sig_r <= 1'b0;
          ack_r      <= {NUM_REQ{1'b0}};
          if (!bus.sync_busy) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_LO;
          end
        end
        default: begin
          state_r    <= IDLE;
          sync_sig_r <= 1'b0;
          ack_r      <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  assign bus.pending    = pending_r;
  assign bus.ack        = ack_r;
  assign bus.sync_sig_a = sync_sig_r;
  assign bus.sync_id    = sync_id_r;

`ifdef PSA_DROP_CNT_EN
  logic [PSA_DROP_CNT_W-1:0] drop_cnt_r;
  logic [NUM_REQ-1:0]        merged_s;
  logic [PSA_DROP_CNT_W:0]   drop_sum_s;
  logic [PSA_DROP_CNT_W-1:0] drop_nxt_s;

  // A request merges when its bit is already pending and not cleared now.
  always_comb begin
    merged_s   = bus.req & pending_r & ~clear_s;
    drop_sum_s = {1'b0, drop_cnt_r} + {4'd0, psa_popcount(PSA_MAX_REQ'(merged_s))};
    if (drop_sum_s > 9'd255) begin
      drop_nxt_s = 8'd255;
    end else begin
      drop_nxt_s = drop_sum_s[PSA_DROP_CNT_W-1:0];
    end
  end

  // Saturating merged-request counter.
  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_nxt_s;
    end
  end

  assign bus.drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Self-checking bench for pulse_sync_arbiter (NUM_REQ=4). A behavioural
// synchronizer raises sync_busy 2 cycles after each sync_sig_a pulse and
// holds it for 6 cycles. Inputs are driven and outputs sampled on negedge.
module tb_pulse_sync_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk_a   = 1'b0;
  logic rst_a_n = 1'b0;

  always #5 clk_a = ~clk_a;

  pulse_sync_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus_if ();

  pulse_sync_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk_a   (clk_a),
    .rst_a_n (rst_a_n),
    .bus     (bus_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int hs_delay   = 0;
  int hs_hold    = 0;
  bit busy_force = 1'b0;

  int launch_ids[$];
  int launch_acks[$];
  int launch_ticks[$];

  // One cycle: go to negedge, clear req, advance the synchronizer model.
  task automatic tick();
    @(negedge clk_a);
    bus_if.req = {N{1'b0}};
    if (bus_if.sync_sig_a === 1'b1) begin
      hs_delay = 2;
    end else if (hs_delay > 0) begin
      hs_delay--;
      if (hs_delay == 0) hs_hold = 6;
    end else if (hs_hold > 0) begin
      hs_hold--;
    end
    bus_if.sync_busy = busy_force | (hs_hold > 0);
  endtask

  task automatic do_reset();
    rst_a_n = 1'b0;
    busy_force = 1'b0;
    hs_delay = 0;
    hs_hold = 0;
    bus_if.req = {N{1'b0}};
    bus_if.sync_busy = 1'b0;
    repeat (2) @(negedge clk_a);
    rst_a_n = 1'b1;
    tick();
  endtask

  // Record every launch seen during n cycles.
  task automatic collect(input int n);
    launch_ids.delete();
    launch_acks.delete();
    launch_ticks.delete();
    for (int t = 0; t < n; t++) begin
      tick();
      if (bus_if.sync_sig_a === 1'b1) begin
        launch_ids.push_back(int'(bus_if.sync_id));
        launch_acks.push_back(int'(bus_if.ack));
        launch_ticks.push_back(t);
      end
    end
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    bus_if.req = 4'b1111;
    bus_if.sync_busy = 1'b0;
    repeat (2) @(negedge clk_a);
    tests_run++; if (bus_if.pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending: got %b want 0000", bus_if.pending); end
    tests_run++; if (bus_if.ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b want 0000", bus_if.ack); end
    tests_run++; if (bus_if.sync_sig_a !== 1'b0) begin tests_failed++; $display("FAIL reset_sig: got %b want 0", bus_if.sync_sig_a); end
    tests_run++; if (bus_if.sync_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", bus_if.sync_id); end
    bus_if.req = {N{1'b0}};
    rst_a_n = 1'b1;
    collect(10);
    tests_run++; if (launch_ids.size() != 0) begin tests_failed++; $display("FAIL reset_no_launch: got %0d launches want 0", launch_ids.size()); end
  endtask

  task automatic test_single();
    int bad_id;
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    tests_run++; if (bus_if.pending !== 4'b0100) begin tests_failed++; $display("FAIL single_pending_set: got %b want 0100", bus_if.pending); end
    tests_run++; if (bus_if.sync_sig_a !== 1'b0) begin tests_failed++; $display("FAIL single_early_sig: got %b want 0", bus_if.sync_sig_a); end
    tick();
    tests_run++; if (bus_if.sync_sig_a !== 1'b1) begin tests_failed++; $display("FAIL single_sig: got %b want 1", bus_if.sync_sig_a); end
    tests_run++; if (bus_if.ack !== 4'b0100) begin tests_failed++; $display("FAIL single_ack: got %b want 0100", bus_if.ack); end
    tests_run++; if (bus_if.sync_id !== 2'd2) begin tests_failed++; $display("FAIL single_id: got %0d want 2", bus_if.sync_id); end
    tests_run++; if (bus_if.pending !== 4'b0000) begin tests_failed++; $display("FAIL single_pending_clr: got %b want 0000", bus_if.pending); end
    bad_id = 0;
    collect(12);
    tests_run++; if (launch_ids.size() != 0) begin tests_failed++; $display("FAIL single_one_pulse: got %0d extra launches want 0", launch_ids.size()); end
    tests_run++; if (bus_if.sync_id !== 2'd2) begin tests_failed++; $display("FAIL single_id_hold: got %0d want 2", bus_if.sync_id); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus_if.req = 4'b1111;
    collect(100);
    tests_run++; if (launch_ids.size() != 4) begin tests_failed++; $display("FAIL rr_count: got %0d want 4", launch_ids.size()); end
    for (int k = 0; k < 4 && k < launch_ids.size(); k++) begin
      tests_run++; if (launch_ids[k] != k) begin tests_failed++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, launch_ids[k], k); end
      tests_run++; if (launch_acks[k] != (1 << k)) begin tests_failed++; $display("FAIL rr_ack[%0d]: got %0h want %0h", k, launch_acks[k], 1 << k); end
      // busy high cycles L+2..L+7, WAIT_LO exits at L+9, one IDLE cycle -> L+10
      if (k > 0) begin
        tests_run++; if (launch_ticks[k] - launch_ticks[k-1] != 10) begin tests_failed++; $display("FAIL rr_gap[%0d]: got %0d want 10", k, launch_ticks[k] - launch_ticks[k-1]); end
      end
    end
    // Pointer back at 0: with requesters 0 and 3 pending, 0 goes first.
    bus_if.req = 4'b1001;
    collect(40);
    tests_run++; if (launch_ids.size() != 2) begin tests_failed++; $display("FAIL rr_wrap_count: got %0d want 2", launch_ids.size()); end
    if (launch_ids.size() >= 2) begin
      tests_run++; if (launch_ids[0] != 0 || launch_ids[1] != 3) begin tests_failed++; $display("FAIL rr_wrap_order: got %0d,%0d want 0,3", launch_ids[0], launch_ids[1]); end
    end
  endtask

  task automatic test_busy_block();
    do_reset();
    busy_force = 1'b1;
    tick();
    bus_if.req = 4'b0010;
    collect(8);
    tests_run++; if (launch_ids.size() != 0) begin tests_failed++; $display("FAIL busy_no_launch: got %0d want 0", launch_ids.size()); end
    tests_run++; if (bus_if.pending !== 4'b0010) begin tests_failed++; $display("FAIL busy_pending: got %b want 0010", bus_if.pending); end
    busy_force = 1'b0;
    tick();
    tests_run++; if (bus_if.sync_sig_a !== 1'b0) begin tests_failed++; $display("FAIL busy_early: got %b want 0", bus_if.sync_sig_a); end
    tick();
    tests_run++; if (bus_if.sync_sig_a !== 1'b1 || bus_if.sync_id !== 2'd1) begin tests_failed++; $display("FAIL busy_release: got sig=%b id=%0d want sig=1 id=1", bus_if.sync_sig_a, bus_if.sync_id); end
    collect(12);
  endtask

  task automatic test_merge();
    bit found;
    do_reset();
    bus_if.req = 4'b0001;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus_if.sync_sig_a === 1'b1) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL merge_first_launch: got none want launch"); end
    for (int p = 0; p < 3; p++) begin
      tick();
      bus_if.req = 4'b1000;
      tick();
    end
    collect(40);
    tests_run++; if (launch_ids.size() != 1) begin tests_failed++; $display("FAIL merge_count: got %0d want 1", launch_ids.size()); end
    if (launch_ids.size() >= 1) begin
      tests_run++; if (launch_ids[0] != 3) begin tests_failed++; $display("FAIL merge_id: got %0d want 3", launch_ids[0]); end
    end
`ifdef PSA_DROP_CNT_EN
    tests_run++; if (bus_if.drop_cnt !== 8'd2) begin tests_failed++; $display("FAIL merge_drop_cnt: got %0d want 2", bus_if.drop_cnt); end
`endif
  endtask

  task automatic test_collision();
    bit found;
    do_reset();
    bus_if.req = 4'b0001;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus_if.sync_sig_a === 1'b1) found = 1'b1;
    end
    tests_run++; if (!found || bus_if.ack !== 4'b0001) begin tests_failed++; $display("FAIL coll_ack: got %b want 0001", bus_if.ack); end
    bus_if.req = 4'b0001;
    tick();
    tests_run++; if (bus_if.pending !== 4'b0001) begin tests_failed++; $display("FAIL coll_pending: got %b want 0001", bus_if.pending); end
    collect(30);
    tests_run++; if (launch_ids.size() != 1 || (launch_ids.size() == 1 && launch_ids[0] != 0)) begin tests_failed++; $display("FAIL coll_relaunch: got %0d launches want 1 for id 0", launch_ids.size()); end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    bus_if.req = 4'b1000;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (bus_if.sync_sig_a === 1'b1) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rmid_launch: got none want launch"); end
    tick();
    bus_if.req = 4'b0110;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      tick();
      if (hs_hold == 3) found = 1'b1;
    end
    tests_run++; if (!found || bus_if.pending !== 4'b0110) begin tests_failed++; $display("FAIL rmid_pending_pre: got %b want 0110", bus_if.pending); end
    rst_a_n = 1'b0;
    #1;
    tests_run++; if (bus_if.pending !== 4'b0000 || bus_if.ack !== 4'b0000) begin tests_failed++; $display("FAIL rmid_clear: got pending=%b ack=%b want 0000/0000", bus_if.pending, bus_if.ack); end
    tests_run++; if (bus_if.sync_sig_a !== 1'b0 || bus_if.sync_id !== 2'd0) begin tests_failed++; $display("FAIL rmid_outs: got sig=%b id=%0d want 0/0", bus_if.sync_sig_a, bus_if.sync_id); end
    hs_delay = 0;
    hs_hold = 0;
    bus_if.sync_busy = 1'b0;
    repeat (2) @(negedge clk_a);
    rst_a_n = 1'b1;
    collect(25);
    tests_run++; if (launch_ids.size() != 0 || bus_if.pending !== 4'b0000) begin tests_failed++; $display("FAIL rmid_after: got %0d launches pending=%b want 0/0000", launch_ids.size(), bus_if.pending); end
  endtask

  task automatic test_random();
    bit          m_pend[N];
    int          m_ptr;
    int          m_drop;
    int          inj;
    int          quiet;
    int          win;
    bit          empty;
    logic [N-1:0] mask;
    do_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = 0;
    m_drop = 0;
    for (int r = 0; r < 20; r++) begin
      busy_force = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) begin
        mask = N'($urandom_range(0, 15));
        bus_if.req = mask;
        for (int i = 0; i < N; i++) if (mask[i]) begin
          if (m_pend[i]) m_drop++;
          m_pend[i] = 1'b1;
        end
        tick();
      end
      busy_force = 1'b0;
      inj = 2;
      quiet = 0;
      empty = 1'b0;
      for (int t = 0; t < 400 && !(empty && quiet >= 15); t++) begin
        tick();
        if (bus_if.sync_sig_a === 1'b1) begin
          win = -1;
          for (int k = 0; k < N; k++) begin
            if (win < 0 && m_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
          end
          tests_run++;
          if (win < 0) begin
            tests_failed++; $display("FAIL rand_unexpected: got launch id=%0d want none", bus_if.sync_id);
          end else begin
            if (int'(bus_if.sync_id) != win) begin tests_failed++; $display("FAIL rand_id: got %0d want %0d", bus_if.sync_id, win); end
            tests_run++; if (int'(bus_if.ack) != (1 << win)) begin tests_failed++; $display("FAIL rand_ack: got %b want %0h", bus_if.ack, 1 << win); end
            m_pend[win] = 1'b0;
            m_ptr = (win + 1) % N;
          end
          if (inj > 0 && $urandom_range(0, 1) == 1) begin
            mask = N'($urandom_range(0, 15));
            bus_if.req = mask;
            for (int i = 0; i < N; i++) if (mask[i]) begin
              if (m_pend[i]) m_drop++;
              m_pend[i] = 1'b1;
            end
            inj--;
          end
          quiet = 0;
        end else begin
          quiet++;
        end
        empty = 1'b1;
        for (int i = 0; i < N; i++) if (m_pend[i]) empty = 1'b0;
      end
      tests_run++; if (!empty || bus_if.pending !== 4'b0000) begin tests_failed++; $display("FAIL rand_drain[%0d]: got pending=%b model_empty=%0d want 0000/1", r, bus_if.pending, empty); end
    end
`ifdef PSA_DROP_CNT_EN
    tests_run++; if (int'(bus_if.drop_cnt) != ((m_drop > 255) ? 255 : m_drop)) begin tests_failed++; $display("FAIL rand_drop_cnt: got %0d want %0d", bus_if.drop_cnt, (m_drop > 255) ? 255 : m_drop); end
`endif
  endtask

  initial begin
    bus_if.req = {N{1'b0}};
    bus_if.sync_busy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_block();
    test_merge();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
